// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX sharing logic: FSM encoding, byte width,
// default guard length and the modular wrap helper used by the picker.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int GUARD_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE
    } tx_state_e;

    // base + off folded back into 0..n-1; base is always < n, off < n
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate at or after ptr, with an
// optional lock that narrows the candidate set to a single owner.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         lock,
    input  logic [W-1:0] owner,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] cand;
    int           pos;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand[i] = req[i] && (!lock || (owner == W'(i)));
        end
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < N; k++) begin
            pos = rr_wrap(int'(ptr), k, N);
            if (!any && cand[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among N_REQ requesters with
// round-robin arbitration and a per-message lock; paces on uart_busy_i.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int GUARD_CYC = GUARD_CYC_DEF
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [UART_BYTE_W*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]               req_last_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic                           uart_wr_o,
    output logic [UART_BYTE_W-1:0]         uart_dat_o,
    input  logic                           uart_busy_i,
    output logic [N_REQ-1:0]               grant_o,
    output logic                           locked_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GRD_W = $clog2(GUARD_CYC + 1);

    tx_state_e               state, state_nxt;
    logic [PTR_W-1:0]        rr_ptr, owner, win_idx, ptr_nxt;
    logic [N_REQ-1:0]        win_gnt;
    logic                    win_any, win_last, accept, guard_hit;
    logic [UART_BYTE_W-1:0]  win_byte;
    logic [GRD_W-1:0]        guard;

    rr_pick #(.N(N_REQ), .W(PTR_W)) u_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .lock  (locked_o),
        .owner (owner),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) win_byte = req_data_i[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign win_last    = |(req_last_i & win_gnt);
    assign accept      = (state == IDLE) && !uart_busy_i && win_any;
    assign req_ready_o = accept ? win_gnt : '0;
    assign ptr_nxt     = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    // this WAIT_BUSY cycle is the GUARD_CYC-th one without busy
    assign guard_hit   = (guard >= GRD_W'(GUARD_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_busy_i)    state_nxt = WAIT_IDLE;
                else if (guard_hit) state_nxt = IDLE;
            end
            WAIT_IDLE: if (!uart_busy_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            uart_wr_o  <= 1'b0;
            uart_dat_o <= '0;
            grant_o    <= '0;
            locked_o   <= 1'b0;
            rr_ptr     <= '0;
            owner      <= '0;
            guard      <= '0;
        end else begin
            // strobe is high exactly for the ISSUE cycle
            uart_wr_o <= (state_nxt == ISSUE);
            if (accept) begin
                uart_dat_o <= win_byte;
                grant_o    <= win_gnt;
                if (win_last) begin
                    locked_o <= 1'b0;
                    rr_ptr   <= ptr_nxt;
                end else begin
                    locked_o <= 1'b1;
                    owner    <= win_idx;
                end
            end
            if (state == ISSUE) begin
                guard <= '0;
            end else if (state == WAIT_BUSY && !uart_busy_i && guard != GRD_W'(GUARD_CYC)) begin
                guard <= guard + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: reset/ready vector table, directed multi-cycle cases and
// randomized traffic checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int G  = 4;
    localparam int BL = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready, grant;
    logic [8*N-1:0] req_data = '0;
    logic           uart_wr, locked, busy_i;
    logic [7:0]     uart_dat;
    logic           ignore_wr = 1'b0, busy_force = 1'b0;
    int             bcnt = 0;

    always #5 clk = ~clk;

    // transmitter model: busy rises the cycle after the strobe, lasts BL cycles
    always @(posedge clk) begin
        if (uart_wr && !ignore_wr) bcnt <= BL;
        else if (bcnt != 0)        bcnt <= bcnt - 1;
    end
    assign busy_i = (bcnt != 0) || busy_force;

    uart_tx_arbiter #(.N_REQ(N), .GUARD_CYC(G)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .uart_wr_o   (uart_wr),
        .uart_dat_o  (uart_dat),
        .uart_busy_i (busy_i),
        .grant_o     (grant),
        .locked_o    (locked)
    );

    int           n_chk = 0, n_pass = 0, cyc = 0;
    logic [8:0]   mq [N][$];
    logic [N-1:0] en = '0;
    logic [7:0]   strobe_q[$], acc_q[$];
    logic [N-1:0] sgnt_q[$];
    int           stime_q[$];
    int           m_ptr = 0, m_owner = 0;
    bit           m_locked = 0, pend = 0, pend_l = 0, prev_acc = 0;
    logic [N-1:0] pend_g;
    logic [7:0]   acc_byte = '0;

    typedef struct {
        logic [N-1:0] v;
        logic         b;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int predict(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i] && (!m_locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (mq[i].size() > 0);
            req_data[i*8 +: 8] = req_valid[i] ? mq[i][0][7:0] : 8'h00;
            req_last[i] = req_valid[i] ? mq[i][0][8] : 1'b0;
        end
        @(negedge clk);
        if (rst) begin
            pend = 0;
            prev_acc = 0;
            return;
        end
        if (pend) begin
            chk("grant", grant, pend_g);
            chk("locked", locked, pend_l);
            pend = 0;
        end
        if (uart_wr) begin
            chk("wr_busy", busy_i, 0);
            chk("wr_after_ready", prev_acc, 1);
            chk("wr_dat", uart_dat, acc_byte);
            strobe_q.push_back(uart_dat);
            sgnt_q.push_back(grant);
            stime_q.push_back(cyc);
        end
        prev_acc = 0;
        if (req_ready != '0) begin
            w = predict(req_valid);
            chk("ready_winner", req_ready, (w < 0) ? 0 : (1 << w));
            chk("ready_busy", busy_i, 0);
            if (w >= 0 && req_ready == N'(1 << w)) begin
                acc_byte = req_data[w*8 +: 8];
                pend_l   = !req_last[w];
                pend_g   = N'(1 << w);
                if (req_last[w]) begin
                    m_locked = 0;
                    m_ptr    = (w + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = w;
                end
                void'(mq[w].pop_front());
                acc_q.push_back(acc_byte);
                pend = 1;
                prev_acc = 1;
            end
        end
    endtask

    task automatic idle_wait(input int k);
        repeat (k) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        for (int i = 0; i < N; i++) mq[i].delete();
        step();
        step();
        rst = 1'b0;
        m_ptr = 0; m_owner = 0; m_locked = 0;
        strobe_q.delete(); acc_q.delete(); sgnt_q.delete(); stime_q.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int b;
        b = 0;
        while (strobe_q.size() < n && b < budget) begin
            step();
            b++;
        end
        if (strobe_q.size() < n) chk({nm, "_timeout"}, strobe_q.size(), n);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_rr[5];
        logic [N-1:0] exp_g[4];
        int pushed, left, b, r, len;

        tbl[0] = '{4'b0000, 1'b0, 4'b0000};
        tbl[1] = '{4'b0001, 1'b0, 4'b0001};
        tbl[2] = '{4'b1010, 1'b0, 4'b0010};
        tbl[3] = '{4'b1000, 1'b0, 4'b1000};
        tbl[4] = '{4'b1111, 1'b0, 4'b0001};
        tbl[5] = '{4'b1111, 1'b1, 4'b0000};
        tbl[6] = '{4'b0110, 1'b0, 4'b0010};
        tbl[7] = '{4'b1100, 1'b0, 4'b0100};

        // reset values
        do_reset();
        chk("rst_wr", uart_wr, 0);
        chk("rst_dat", uart_dat, 0);
        chk("rst_grant", grant, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", req_ready, 0);

        // combinational ready from IDLE with rr_ptr=0; valid dropped before the edge
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req_valid  = tbl[i].v;
            req_last   = '1;
            busy_force = tbl[i].b;
            @(negedge clk);
            chk($sformatf("tbl_ready%0d", i), req_ready, tbl[i].exp);
            #1;
            req_valid  = '0;
            busy_force = 1'b0;
        end

        // single byte
        do_reset();
        mq[0].push_back({1'b1, 8'h41});
        en = '1;
        wait_strobes(1, 40, "single");
        if (strobe_q.size() >= 1) chk("single_dat", strobe_q[0], 8'h41);
        idle_wait(20);

        // round robin, all valid with last=1
        do_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].push_back({1'b1, 8'(8'h10 + i)});
            mq[i].push_back({1'b1, 8'(8'h10 + i)});
        end
        en = '1;
        exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        wait_strobes(5, 200, "rr");
        if (strobe_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_dat%0d", i), strobe_q[i], exp_rr[i]);
            for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), sgnt_q[i], exp_g[i]);
            chk("rr_spacing", stime_q[1] - stime_q[0], BL + 3);
        end
        wait_strobes(8, 200, "rr_drain");
        idle_wait(20);

        // lock keeps "AB" contiguous against a competing requester
        do_reset();
        mq[2].push_back({1'b1, 8'h5A});
        mq[1].push_back({1'b0, 8'h41});
        mq[1].push_back({1'b1, 8'h42});
        en = '1;
        wait_strobes(1, 40, "lock_first");
        chk("lock_mid", locked, 1);
        wait_strobes(3, 200, "lock");
        if (strobe_q.size() >= 3) begin
            chk("lock_dat0", strobe_q[0], 8'h41);
            chk("lock_dat1", strobe_q[1], 8'h42);
            chk("lock_dat2", strobe_q[2], 8'h5A);
        end
        idle_wait(20);

        // stalled owner holds the lock, req0 waits
        do_reset();
        mq[3].push_back({1'b0, 8'h33});
        mq[0].push_back({1'b1, 8'h30});
        en = 4'b1000;
        wait_strobes(1, 40, "stall_first");
        mq[3].push_back({1'b1, 8'h34});
        en = 4'b0001;
        idle_wait(50);
        chk("stall_no_accept", acc_q.size(), 1);
        chk("stall_locked", locked, 1);
        en = 4'b1001;
        wait_strobes(3, 200, "stall");
        if (strobe_q.size() >= 3) begin
            chk("stall_dat1", strobe_q[1], 8'h34);
            chk("stall_dat2", strobe_q[2], 8'h30);
        end
        idle_wait(20);

        // guard recovery when the transmitter drops the strobe
        do_reset();
        ignore_wr = 1'b1;
        mq[0].push_back({1'b1, 8'h55});
        mq[0].push_back({1'b1, 8'h56});
        en = '1;
        wait_strobes(2, 100, "guard");
        if (strobe_q.size() >= 2) chk("guard_gap", stime_q[1] - stime_q[0], G + 2);
        ignore_wr = 1'b0;
        mq[1].push_back({1'b1, 8'h66});
        wait_strobes(3, 100, "guard_after");
        if (strobe_q.size() >= 3) chk("guard_after_dat", strobe_q[2], 8'h66);
        idle_wait(20);

        // reset during WAIT_IDLE, after rr_ptr has moved to 2
        do_reset();
        en = '1;
        mq[1].push_back({1'b1, 8'h70});
        wait_strobes(1, 40, "mid_a");
        idle_wait(20);
        mq[1].push_back({1'b0, 8'h71});
        wait_strobes(2, 40, "mid_b");
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_wr", uart_wr, 0);
        chk("mid_rst_dat", uart_dat, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_locked", locked, 0);
        rst = 1'b0;
        m_ptr = 0; m_owner = 0; m_locked = 0;
        mq[0].push_back({1'b1, 8'h80});
        mq[2].push_back({1'b1, 8'h82});
        wait_strobes(3, 100, "mid_after");
        if (strobe_q.size() >= 3) chk("mid_rst_ptr", strobe_q[2], 8'h80);
        idle_wait(40);

        // randomized traffic: random messages, random enable stalls
        do_reset();
        pushed = 0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                r   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 3);
                if (mq[r].size() < 6) begin
                    for (int j = 0; j < len; j++)
                        mq[r].push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                    pushed += len;
                end
            end
            if ($urandom_range(0, 7) == 0) en = N'($urandom);
            step();
        end
        en = '1;
        b = 0;
        left = 1;
        while (left != 0 && b < 4000) begin
            left = 0;
            for (int i = 0; i < N; i++) left += mq[i].size();
            if (left != 0) step();
            b++;
        end
        chk("rand_drain", left, 0);
        idle_wait(20);
        chk("rand_total", strobe_q.size(), pushed);
        chk("rand_acc", acc_q.size(), pushed);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
